// File: rtl/sha256_responder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : sha256_responder_pkg                                       |
// | Brief   : SHA-256 IV constant and responder FSM state encodings      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package sha256_responder_pkg;

   localparam logic [255:0] c_sha256_iv = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD0 = 3'd1,
      WAIT0 = 3'd2,
      LOAD1 = 3'd3,
      WAIT1 = 3'd4,
      FIN   = 3'd5
   } state_t;

endpackage
`default_nettype wire

// File: rtl/sha256_responder_chain.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : sha256_responder_chain                                     |
// | Brief   : working chaining value and saved intermediate value        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sha256_responder_chain
   import sha256_responder_pkg::*;
#(
   parameter int HASH_LEN = 256
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start_load,
   input  logic                use_saved,
   input  logic                core_load,
   input  logic [HASH_LEN-1:0] core_value,
   input  logic                commit,
   output logic [HASH_LEN-1:0] chain
);

   localparam logic [HASH_LEN-1:0] c_iv = HASH_LEN'(c_sha256_iv);

   logic [HASH_LEN-1:0] r_chain;
   logic [HASH_LEN-1:0] r_saved;

   // The saved value is read only at start and written only at commit, so a
   // request that both continues and stores sees the old value.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_chain <= '0;
         r_saved <= c_iv;
      end else begin
         if (start_load) begin
            r_chain <= use_saved ? r_saved : c_iv;
         end else if (core_load) begin
            r_chain <= core_value;
         end
         if (commit) begin
            r_saved <= r_chain;
         end
      end
   end

   assign chain = r_chain;

endmodule
`default_nettype wire

// File: rtl/sha256_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : sha256_responder                                           |
// | Brief   : request/compression-core sequencer for 1- or 2-block SHA256|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sha256_responder
   import sha256_responder_pkg::*;
#(
   parameter int HASH_LEN  = 256,
   parameter int BLOCK_LEN = 512
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   hash_start,
   input  logic [2*BLOCK_LEN-1:0] hash_data_in,
   input  logic                   message_length,
   input  logic                   continue_intermediate,
   input  logic                   store_intermediate,
   output logic                   hash_done,
   output logic [HASH_LEN-1:0]    hash_data_out,
   output logic                   busy,
   output logic                   comp_start,
   output logic [BLOCK_LEN-1:0]   comp_block,
   output logic [HASH_LEN-1:0]    comp_state_in,
   input  logic                   comp_done,
   input  logic [HASH_LEN-1:0]    comp_state_out
);

   state_t                 r_state;
   logic [2*BLOCK_LEN-1:0] r_msg;
   logic                   r_two_blocks;
   logic                   r_store;
   logic                   r_hash_done;
   logic [HASH_LEN-1:0]    r_hash_data_out;
   logic                   r_busy;
   logic                   r_comp_start;
   logic [BLOCK_LEN-1:0]   r_comp_block;
   logic [HASH_LEN-1:0]    r_comp_state_in;

   logic                   w_accept;
   logic                   w_core_load;
   logic                   w_commit;
   logic [HASH_LEN-1:0]    w_chain;

   assign w_accept    = (r_state == IDLE) && hash_start;
   assign w_core_load = ((r_state == WAIT0) || (r_state == WAIT1)) && comp_done;
   assign w_commit    = (r_state == FIN) && r_store;

   sha256_responder_chain #(
      .HASH_LEN (HASH_LEN)
   ) u_chain (
      .clk        (clk),
      .reset      (reset),
      .start_load (w_accept),
      .use_saved  (continue_intermediate),
      .core_load  (w_core_load),
      .core_value (comp_state_out),
      .commit     (w_commit),
      .chain      (w_chain)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state         <= IDLE;
         r_msg           <= '0;
         r_two_blocks    <= 1'b0;
         r_store         <= 1'b0;
         r_hash_done     <= 1'b0;
         r_hash_data_out <= '0;
         r_busy          <= 1'b0;
         r_comp_start    <= 1'b0;
         r_comp_block    <= '0;
         r_comp_state_in <= '0;
      end else begin
         r_hash_done  <= 1'b0;
         r_comp_start <= 1'b0;
         case (r_state)
            IDLE: begin
               if (hash_start) begin
                  r_msg        <= hash_data_in;
                  r_two_blocks <= message_length;
                  r_store      <= store_intermediate;
                  r_busy       <= 1'b1;
                  r_state      <= LOAD0;
               end
            end
            LOAD0: begin
               r_comp_start    <= 1'b1;
               r_comp_block    <= r_msg[2*BLOCK_LEN-1 -: BLOCK_LEN];
               r_comp_state_in <= w_chain;
               r_state         <= WAIT0;
            end
            WAIT0: begin
               if (comp_done) begin
                  r_state <= r_two_blocks ? LOAD1 : FIN;
               end
            end
            LOAD1: begin
               r_comp_start    <= 1'b1;
               r_comp_block    <= r_msg[BLOCK_LEN-1:0];
               r_comp_state_in <= w_chain;
               r_state         <= WAIT1;
            end
            WAIT1: begin
               if (comp_done) begin
                  r_state <= FIN;
               end
            end
            FIN: begin
               r_hash_done     <= 1'b1;
               r_hash_data_out <= w_chain;
               r_busy          <= 1'b0;
               r_state         <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign hash_done     = r_hash_done;
   assign hash_data_out = r_hash_data_out;
   assign busy          = r_busy;
   assign comp_start    = r_comp_start;
   assign comp_block    = r_comp_block;
   assign comp_state_in = r_comp_state_in;

endmodule
`default_nettype wire

// File: tb/tb_sha256_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_sha256_responder                                        |
// | Brief   : bench with SHA-256 core model and request-level scoreboard |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_sha256_responder;

   localparam int c_core_lat = 4;

   localparam logic [31:0] c_k [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };
   localparam logic [255:0] c_iv =
      256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
   localparam logic [255:0] c_abc_digest =
      256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [255:0] c_two_digest =
      256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
   localparam logic [511:0] c_abc_blk = {32'h61626380, 416'h0, 64'h18};
   localparam logic [511:0] c_two_b0 = {
      448'h61626364_62636465_63646566_64656667_65666768_66676869_6768696a_68696a6b_696a6b6c_6a6b6c6d_6b6c6d6e_6c6d6e6f_6d6e6f70_6e6f7071,
      64'h80000000_00000000};
   localparam logic [511:0] c_two_b1 = {448'h0, 64'h1c0};

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          hash_start = 1'b0;
   logic [1023:0] hash_data_in = '0;
   logic          message_length = 1'b0;
   logic          continue_intermediate = 1'b0;
   logic          store_intermediate = 1'b0;
   logic          hash_done;
   logic [255:0]  hash_data_out;
   logic          busy;
   logic          comp_start;
   logic [511:0]  comp_block;
   logic [255:0]  comp_state_in;
   logic          comp_done = 1'b0;
   logic [255:0]  comp_state_out = '0;

   always #5 clk = ~clk;

   sha256_responder #(
      .HASH_LEN  (256),
      .BLOCK_LEN (512)
   ) dut (
      .clk                   (clk),
      .reset                 (reset),
      .hash_start            (hash_start),
      .hash_data_in          (hash_data_in),
      .message_length        (message_length),
      .continue_intermediate (continue_intermediate),
      .store_intermediate    (store_intermediate),
      .hash_done             (hash_done),
      .hash_data_out         (hash_data_out),
      .busy                  (busy),
      .comp_start            (comp_start),
      .comp_block            (comp_block),
      .comp_state_in         (comp_state_in),
      .comp_done             (comp_done),
      .comp_state_out        (comp_state_out)
   );

   function automatic logic [31:0] ror(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
      logic [31:0] w [64];
      logic [31:0] a, b, c, d, e, f, g, h, s0, s1, t1, t2;
      for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
      for (int t = 16; t < 64; t++) begin
         s0   = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
         s1   = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
         w[t] = w[t-16] + s0 + w[t-7] + s1;
      end
      {a, b, c, d, e, f, g, h} = hin;
      for (int t = 0; t < 64; t++) begin
         t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + c_k[t] + w[t];
         t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
         h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
      end
      return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
              hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
   endfunction

   int checks = 0;
   int errors = 0;

   task automatic check_vec(input string name, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // Compression core stand-in: answers c_core_lat edges after it samples comp_start.
   int           core_cnt = 0;
   logic [255:0] core_res = '0;
   always @(negedge clk) begin
      comp_done = 1'b0;
      if (core_cnt > 0) begin
         core_cnt--;
         if (core_cnt == 0) begin
            comp_done      = 1'b1;
            comp_state_out = core_res;
         end
      end
      if (comp_start) begin
         core_res = sha_compress(comp_state_in, comp_block);
         core_cnt = c_core_lat;
      end
   end

   // Request-level reference: accepted requests finish after the documented latency.
   int           edge_n = 0;
   bit           m_active = 1'b0;
   bit           m_done_now = 1'b0;
   bit           m_two = 1'b0;
   bit           m_store = 1'b0;
   int           m_k0 = 0;
   int           m_done_edge = 0;
   logic [255:0] m_saved = c_iv;
   logic [255:0] m_out = '0;
   logic [255:0] m_chain0 = '0;
   logic [255:0] m_chain1 = '0;
   logic [255:0] m_digest = '0;
   logic [511:0] m_b0 = '0;
   logic [511:0] m_b1 = '0;

   always @(posedge clk) begin
      edge_n++;
      m_done_now = 1'b0;
      if (reset) begin
         m_active = 1'b0;
         m_out    = '0;
         m_saved  = c_iv;
      end else if (m_active && edge_n == m_done_edge) begin
         m_active   = 1'b0;
         m_done_now = 1'b1;
         m_out      = m_digest;
         if (m_store) m_saved = m_digest;
      end else if (!m_active && hash_start) begin
         m_active    = 1'b1;
         m_k0        = edge_n;
         m_two       = message_length;
         m_store     = store_intermediate;
         m_done_edge = edge_n + (message_length ? 2*c_core_lat + 5 : c_core_lat + 3);
         m_b0        = hash_data_in[1023:512];
         m_b1        = hash_data_in[511:0];
         m_chain0    = continue_intermediate ? m_saved : c_iv;
         m_chain1    = sha_compress(m_chain0, m_b0);
         m_digest    = m_two ? sha_compress(m_chain1, m_b1) : m_chain1;
      end
   end

   bit checking = 1'b0;
   int n_done = 0;
   int n_cs = 0;
   always @(negedge clk) begin
      if (checking) begin
         logic exp_cs;
         logic first;
         first  = (edge_n == m_k0 + 1);
         exp_cs = m_active && (first || (m_two && edge_n == m_k0 + c_core_lat + 3));
         check_bit("busy", busy, m_active);
         check_bit("hash_done", hash_done, m_done_now);
         check_bit("comp_start", comp_start, exp_cs);
         check_vec("hash_data_out", {256'h0, hash_data_out}, {256'h0, m_out});
         if (exp_cs) begin
            check_vec("comp_block", comp_block, first ? m_b0 : m_b1);
            check_vec("comp_state_in", {256'h0, comp_state_in}, {256'h0, first ? m_chain0 : m_chain1});
         end
         if (hash_done) n_done++;
         if (comp_start) n_cs++;
      end
   end

   task automatic start_req(input logic [1023:0] d, input logic len, input logic cont, input logic store);
      @(posedge clk); #1;
      hash_data_in          = d;
      message_length        = len;
      continue_intermediate = cont;
      store_intermediate    = store;
      hash_start            = 1'b1;
      @(posedge clk); #1;
      hash_start            = 1'b0;
      continue_intermediate = 1'b0;
      store_intermediate    = 1'b0;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int d0, c0;
      @(posedge clk); #1;
      checking = 1'b1;
      wait_cycles(2); #1;
      reset = 1'b0;
      check_vec("reset comp_block", comp_block, 512'h0);
      check_vec("reset comp_state_in", {256'h0, comp_state_in}, 512'h0);

      // one-block "abc"
      d0 = n_done; c0 = n_cs;
      start_req({c_abc_blk, 512'h0}, 1'b0, 1'b0, 1'b0);
      wait_cycles(c_core_lat + 4);
      @(negedge clk);
      check_vec("abc digest", {256'h0, hash_data_out}, {256'h0, c_abc_digest});
      check_vec("abc model", {256'h0, m_out}, {256'h0, c_abc_digest});
      check_vec("abc done count", 512'(n_done - d0), 512'd1);

      // two-block message
      d0 = n_done; c0 = n_cs;
      start_req({c_two_b0, c_two_b1}, 1'b1, 1'b0, 1'b0);
      wait_cycles(2*c_core_lat + 6);
      @(negedge clk);
      check_vec("two digest", {256'h0, hash_data_out}, {256'h0, c_two_digest});
      check_vec("two model", {256'h0, m_out}, {256'h0, c_two_digest});
      check_vec("two comp_start count", 512'(n_cs - c0), 512'd2);
      check_vec("two done count", 512'(n_done - d0), 512'd1);

      // split across two requests via the saved chaining value
      start_req({c_two_b0, 512'h0}, 1'b0, 1'b0, 1'b1);
      wait_cycles(c_core_lat + 4);
      start_req({c_two_b1, 512'h0}, 1'b0, 1'b1, 1'b0);
      wait_cycles(c_core_lat + 4);
      @(negedge clk);
      check_vec("split digest", {256'h0, hash_data_out}, {256'h0, c_two_digest});

      // continue and store in the same request, then continue again
      start_req({c_abc_blk, 512'h0}, 1'b0, 1'b1, 1'b1);
      wait_cycles(c_core_lat + 4);
      start_req({c_abc_blk, 512'h0}, 1'b0, 1'b1, 1'b0);
      wait_cycles(c_core_lat + 4);

      // start pulse during WAIT0 must be dropped
      d0 = n_done; c0 = n_cs;
      start_req({c_abc_blk, 512'h0}, 1'b0, 1'b0, 1'b0);
      start_req({c_two_b0, c_two_b1}, 1'b1, 1'b0, 1'b0);
      wait_cycles(2*c_core_lat + 6);
      @(negedge clk);
      check_vec("wait0 start digest", {256'h0, hash_data_out}, {256'h0, c_abc_digest});
      check_vec("wait0 start comp_start count", 512'(n_cs - c0), 512'd1);
      check_vec("wait0 start done count", 512'(n_done - d0), 512'd1);

      // start pulse in the FIN cycle is dropped, next cycle is accepted
      d0 = n_done;
      start_req({c_abc_blk, 512'h0}, 1'b0, 1'b0, 1'b0);
      wait_cycles(c_core_lat + 1);
      start_req({c_abc_blk, 512'h0}, 1'b0, 1'b1, 1'b0);
      start_req({c_two_b0, c_two_b1}, 1'b1, 1'b0, 1'b0);
      wait_cycles(2*c_core_lat + 6);
      @(negedge clk);
      check_vec("fin start digest", {256'h0, hash_data_out}, {256'h0, c_two_digest});
      check_vec("fin start done count", 512'(n_done - d0), 512'd2);

      // reset during WAIT1 with a stray comp_done afterwards
      start_req({c_two_b0, 512'h0}, 1'b0, 1'b0, 1'b1);
      wait_cycles(c_core_lat + 4);
      d0 = n_done;
      start_req({c_two_b0, c_two_b1}, 1'b1, 1'b0, 1'b0);
      wait_cycles(c_core_lat + 4); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      wait_cycles(2*c_core_lat + 6);
      @(negedge clk);
      check_bit("abort busy", busy, 1'b0);
      check_vec("abort done count", 512'(n_done - d0), 512'd0);
      start_req({c_abc_blk, 512'h0}, 1'b0, 1'b1, 1'b0);
      wait_cycles(c_core_lat + 4);
      @(negedge clk);
      check_vec("post reset continue digest", {256'h0, hash_data_out}, {256'h0, c_abc_digest});

      checking = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sha256_responder.md
SHA256_RESPONDER -- requirements
Module: sha256_responder

Interface
REQ-001 SHALL have parameter HASH_LEN, default 256, meaning the digest and chaining-value width in bits.
REQ-002 SHALL have parameter BLOCK_LEN, default 512, meaning the compression block width in bits.
REQ-003 SHALL have port clk, input, 1, the clock; reset is synchronous, active-high.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port hash_start, input, 1, a one-cycle request pulse from the initiator.
REQ-006 SHALL have port hash_data_in, input, 1024, the pre-padded message; block 0 is [1023:512] and block 1 is [511:0].
REQ-007 SHALL have port message_length, input, 1: 0 means one block, 1 means two blocks.
REQ-008 SHALL have port continue_intermediate, input, 1: 1 means start from the saved chaining value rather than the IV.
REQ-009 SHALL have port store_intermediate, input, 1: 1 means save the final chaining value.
REQ-010 SHALL have port hash_done, output, 1, a one-cycle completion pulse.
REQ-011 SHALL have port hash_data_out, output, HASH_LEN, the digest, with H0 in the MSBs.
REQ-012 SHALL have port busy, output, 1, asserted while a request is in progress.
REQ-013 SHALL have port comp_start, output, 1, a one-cycle start pulse to the compression core.
REQ-014 SHALL have port comp_block, output, BLOCK_LEN, the block to be compressed.
REQ-015 SHALL have port comp_state_in, output, HASH_LEN, the input chaining value.
REQ-016 SHALL have port comp_done, input, 1, a one-cycle pulse from the core.
REQ-017 SHALL have port comp_state_out, input, HASH_LEN, the core's output chaining value, valid when comp_done is high.

Function
REQ-018 SHALL use the FSM states IDLE, LOAD0, WAIT0, LOAD1, WAIT1 and FIN.
REQ-019 SHALL, in IDLE on hash_start, register hash_data_in, message_length and store_intermediate, and go to LOAD0.
REQ-020 SHALL, on that same start edge, latch the chaining value: the saved value if continue_intermediate=1, otherwise the SHA-256 IV.
REQ-021 SHALL, in LOAD0, pulse comp_start for exactly one cycle with comp_block = block 0, and go to WAIT0.
REQ-022 SHALL, in WAIT0 on comp_done, replace the chaining value with comp_state_out.
REQ-023 SHALL, in WAIT0 on comp_done, go to LOAD1 if the registered message_length=1, else to FIN.
REQ-024 SHALL handle LOAD1 and WAIT1 as LOAD0 and WAIT0 do, but with block 1; WAIT1 always exits to FIN on comp_done.
REQ-025 SHALL, in FIN, pulse hash_done for one cycle, drive hash_data_out with the chaining value, and return to IDLE.
REQ-026 SHALL, in FIN, overwrite the saved value with the final chaining value if the registered store_intermediate=1.
REQ-027 SHALL hold hash_data_out stable from FIN until the next FIN.
REQ-028 SHALL make latency equal to core latency plus 3 cycles for one block, or 2×core latency plus 5 cycles for two blocks, counted from the hash_start edge to the hash_done cycle.
REQ-029 SHALL ignore hash_start when not in IDLE, with no state change and no queuing.
REQ-030 SHALL ignore comp_done outside WAIT0 and WAIT1.
REQ-031 SHALL, when continue_intermediate=1 and store_intermediate=1 together, read the old saved value at start and write the new one only in FIN.
REQ-032 SHALL assert busy from the cycle after hash_start was accepted through FIN inclusive, and deassert it in IDLE.
REQ-033 SHALL, when hash_start arrives in the FIN cycle, ignore it; the next request is accepted no earlier than the following cycle.
REQ-034 SHALL hold comp_block and comp_state_in stable from LOAD0 or LOAD1 until the matching comp_done.

Reset
REQ-035 SHALL, on reset, put the FSM in IDLE and drive hash_done=0, busy=0, comp_start=0, hash_data_out=0, comp_block=0 and comp_state_in=0.
REQ-036 SHALL, on reset, set the saved intermediate value to the IV.
REQ-037 SHALL let reset asserted mid-operation abort the request; no hash_done is issued, and a comp_done arriving afterwards is ignored.

Structure
REQ-038 SHALL place the SHA-256 IV constant (8×32-bit) and the FSM state encodings in the shared hash package.
REQ-039 SHALL instantiate the existing compression core, sha256_compress, in the enclosing hash wrapper rather than in this block; this block is pure control and data-path registers.

Verification
REQ-040 SHALL cover: "abc" padded into one block, message_length=0, continue_intermediate=0 -> one hash_done with hash_data_out=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
REQ-041 SHALL cover: "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" padded into two blocks, message_length=1 -> hash_data_out=248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1, with exactly two comp_start pulses.
REQ-042 SHALL cover: block 0 of the two-block vector with store_intermediate=1, then block 1 (in [1023:512]) with continue_intermediate=1 and message_length=0 -> the same 248d6a61... digest.
REQ-043 SHALL cover: hash_start pulsed during WAIT0 -> no extra comp_start, and a single hash_done with the correct digest.
REQ-044 SHALL cover: reset asserted during WAIT1, then a stray comp_done -> busy=0, no hash_done, and a subsequent continue_intermediate request uses the IV.
